// File: rtl/hier_path_decoder.sv
// Hierarchical path decoder.
//
// Collects a path of base-FANOUT digits (most significant level first) and
// folds them into a flat node index. A path ends on the digit flagged by
// in_last. The decoded result is then held on the output side until the
// consumer takes it.
//
// A path is marked bad if any digit is >= FANOUT or if it is longer than
// DEPTH digits. Once a path is bad, the index stops changing. The digit
// count keeps advancing, but it stops at DEPTH+1.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  digit handshake; in_digit, in_last qualify it
//   out_valid / out_ready result handshake
//   out_index            flat node index (0 while collecting)
//   out_depth            digits received, saturating at DEPTH+1 (0 while collecting)
//   out_err              path invalid (0 while collecting)
module hier_path_decoder #(
  parameter int unsigned FANOUT = 5,
  parameter int unsigned DEPTH  = 10,
  parameter int unsigned IDX_W  = 24,
  parameter int unsigned DIG_W  = 3,
  parameter int unsigned CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIG_W-1:0] in_digit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [CNT_W-1:0] out_depth,
  output logic             out_err
);

  localparam logic [IDX_W-1:0] FanoutIdx = IDX_W'(FANOUT);
  localparam logic [CNT_W-1:0] DepthCnt  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DepthSat  = CNT_W'(DEPTH + 1);

  typedef enum logic [0:0] {StAccum, StOut} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              digit_fire;
  logic              result_fire;
  logic              digit_bad;
  logic              too_deep;

  assign digit_fire  = in_valid && (state_q == StAccum);
  assign result_fire = out_ready && (state_q == StOut);

  // Compare in 32 bits so a FANOUT wider than the digit never wraps.
  assign digit_bad = (32'(in_digit) >= FANOUT);
  // This digit would be number DEPTH+1 or later.
  assign too_deep  = (cnt_q >= DepthCnt);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAccum;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccum: if (digit_fire && in_last) state_d = StOut;
      StOut:   if (result_fire)           state_d = StAccum;
      default:                            state_d = StAccum;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_index = '0;
    out_depth = '0;
    out_err   = 1'b0;
    unique case (state_q)
      StAccum: begin
        in_ready = 1'b1;
      end
      StOut: begin
        out_valid = 1'b1;
        out_index = acc_q;
        out_depth = cnt_q;
        out_err   = err_q;
      end
      default: begin
        in_ready = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: accumulator, digit count, sticky error
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (result_fire) begin
      acc_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
    end else if (digit_fire) begin
      if (cnt_q != DepthSat) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (digit_bad || too_deep) begin
        err_d = 1'b1;
      end
      // Only a good digit within depth on a still-clean path moves the index.
      if (!err_q && !digit_bad && !too_deep) begin
        acc_d = acc_q * FanoutIdx + IDX_W'(in_digit);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_hier_path_decoder.sv
// Directed, table-driven bench for hier_path_decoder (default parameters).
module tb_hier_path_decoder;

  localparam int unsigned IDX_W = 24;
  localparam int unsigned DIG_W = 3;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [DIG_W-1:0] in_digit;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic [CNT_W-1:0] out_depth;
  logic             out_err;

  int checks;
  int failures;

  hier_path_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digit  (in_digit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_depth (out_depth),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef int dig_arr_t[12];

  typedef struct {
    string       name;
    int          n;
    logic [47:0] dig;   // digit i at [3*i +: 3]
    bit          gap;   // idle cycle with junk inputs between digits
    int          exp_index;
    int          exp_depth;
    bit          exp_err;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [47:0] pk(input dig_arr_t d);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 12; i++) r[3*i +: 3] = 3'(d[i]);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_index"}, int'(out_index), 0);
    chk({tag, "_out_depth"}, int'(out_depth), 0);
    chk({tag, "_out_err"}, int'(out_err), 0);
  endtask

  // Drives one path; returns #1 after the edge that took the last digit.
  task automatic send_path(input string tag, input int n, input logic [47:0] dig,
                           input bit gap);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_in_ready_pre"}, int'(in_ready), 1);
      in_valid = 1'b1;
      in_digit = dig[3*i +: 3];
      in_last  = (i == n - 1);
      @(posedge clk); #1;
      if (gap && i != n - 1) begin
        in_valid = 1'b0;
        in_digit = 3'd7;
        in_last  = 1'b1;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    in_digit = 3'd6;
    in_last  = 1'b1;
  endtask

  task automatic chk_result(input string tag, input int idx, input int dep, input bit err);
    chk({tag, "_out_valid"}, int'(out_valid), 1);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_out_index"}, int'(out_index), idx);
    chk({tag, "_out_depth"}, int'(out_depth), dep);
    chk({tag, "_out_err"}, int'(out_err), int'(err));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    in_valid = 1'b0;
    in_digit = '0;
    in_last  = 1'b0;
    out_ready = 1'b1;
    rst_n    = 1'b0;

    vecs[0] = '{"r24_108", 10, pk('{0,0,0,0,0,0,0,4,1,3,0,0}), 1'b0, 108, 10, 1'b0};
    vecs[1] = '{"r25_all4", 10, pk('{4,4,4,4,4,4,4,4,4,4,0,0}), 1'b0, 9765624, 10, 1'b0};
    vecs[2] = '{"r26_123", 3, pk('{1,2,3,0,0,0,0,0,0,0,0,0}), 1'b0, 38, 3, 1'b0};
    vecs[3] = '{"r26_251", 3, pk('{2,5,1,0,0,0,0,0,0,0,0,0}), 1'b0, 2, 3, 1'b1};
    vecs[4] = '{"r27_11ones", 11, pk('{1,1,1,1,1,1,1,1,1,1,1,0}), 1'b0, 2441406, 11, 1'b1};
    vecs[5] = '{"one_digit", 1, pk('{3,0,0,0,0,0,0,0,0,0,0,0}), 1'b0, 3, 1, 1'b0};
    vecs[6] = '{"one_bad", 1, pk('{7,0,0,0,0,0,0,0,0,0,0,0}), 1'b0, 0, 1, 1'b1};
    vecs[7] = '{"gap_44", 2, pk('{4,4,0,0,0,0,0,0,0,0,0,0}), 1'b1, 24, 2, 1'b0};
    vecs[8] = '{"sat_12", 12, pk('{0,0,0,0,0,0,0,0,0,0,0,0}), 1'b0, 0, 11, 1'b1};

    // Reset state, asserted asynchronously.
    #3;
    chk_idle("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table vectors with out_ready held high.
    for (int v = 0; v < 9; v++) begin
      send_path(vecs[v].name, vecs[v].n, vecs[v].dig, vecs[v].gap);
      chk_result(vecs[v].name, vecs[v].exp_index, vecs[v].exp_depth, vecs[v].exp_err);
      @(posedge clk); #1;
      chk_idle({vecs[v].name, "_after"});
    end

    // Back-pressure: result held for 5 cycles, digits offered meanwhile are ignored.
    out_ready = 1'b0;
    send_path("bp", 3, pk('{1,2,3,0,0,0,0,0,0,0,0,0}), 1'b0);
    in_valid = 1'b1;
    in_digit = 3'd4;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk_result("bp_hold", 38, 3, 1'b0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk_result("bp_release", 38, 3, 1'b0);
    @(posedge clk); #1;
    chk_idle("bp_after");
    @(posedge clk); #1;
    chk("bp_single_handshake", int'(out_valid), 0);

    // Reset in the middle of a path: no result afterwards, fresh path decodes cleanly.
    in_valid = 1'b1;
    in_last  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_digit = 3'd1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk_idle("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_path("postrst", 1, pk('{3,0,0,0,0,0,0,0,0,0,0,0}), 1'b0);
    chk_result("postrst", 3, 1, 1'b0);
    @(posedge clk); #1;
    chk_idle("postrst_after");

    // Reset while a result is pending drops it.
    out_ready = 1'b0;
    send_path("pend", 2, pk('{1,1,0,0,0,0,0,0,0,0,0,0}), 1'b0);
    chk_result("pend", 6, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_idle("pend_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk_idle("pend_gone");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
